// File: rtl/inport_ioc_flt.sv
// inport_ioc_flt -- interrupt-on-change input port with filtering.
//
// Each external input passes through a synchronizer and a per-bit glitch
// filter. An accepted level change can set a sticky pending flag, selected
// per bit and per direction. The port exposes three bus registers:
//   ADDR   : filtered input value          (read only)
//   ADDR+1 : pending flags                 (read, write-1-to-clear)
//   ADDR+2 : interrupt mask                (read/write)
// port_out is zero whenever the port is not being read, so it can be
// OR-combined with the other ports on the bus.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   address       bus address
//   ren / wen     read / write strobes
//   data_in       bus write data
//   port_in       asynchronous external inputs (WIDTH bits)
//   ioc_pos_conf  per-bit rising-edge flag enable
//   ioc_neg_conf  per-bit falling-edge flag enable
//   port_out      registered read data, one clock after ren
//   int_out       interrupt request, |(flags & mask)
//   int_ack       clears all pending flags
module inport_ioc_flt #(
  parameter logic [7:0] ADDR        = 8'h03,
  parameter int         WIDTH       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic             ren,
  input  logic             wen,
  input  logic [7:0]       data_in,
  input  logic [WIDTH-1:0] port_in,
  input  logic [WIDTH-1:0] ioc_pos_conf,
  input  logic [WIDTH-1:0] ioc_neg_conf,
  output logic [7:0]       port_out,
  output logic             int_out,
  input  logic             int_ack
);

  // Register addresses wrap modulo 256 through the 8-bit arithmetic.
  localparam logic [7:0] ADDR_FLG   = ADDR + 8'd1;
  localparam logic [7:0] ADDR_MSK   = ADDR + 8'd2;
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);
  localparam logic [3:0] FILT_LAST  = (FILT_CYCLES > 0) ? 4'(FILT_CYCLES - 1) : 4'd0;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_filt;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_mask;
  logic [3:0]       r_cnt [WIDTH];
  logic [2:0]       r_prime_cnt;
  logic             r_primed;
  logic [7:0]       r_port_out;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_filt_nxt;
  logic [3:0]       w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_evt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_flags_nxt;
  logic             w_wr_flg;
  logic             w_wr_msk;
  logic             w_unused;

  // Bus bits at WIDTH and above are ignored on writes.
  assign w_unused = ^data_in;

  function automatic logic [7:0] zext(input logic [WIDTH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Stage: input synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= port_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Stage: glitch filter. Until primed, the filter only waits for the
  // synchronizer to fill and then loads its output without raising events,
  // so inputs already high at reset release do not interrupt.
  always_comb begin
    w_filt_nxt = r_filt;
    for (int i = 0; i < WIDTH; i++) w_cnt_nxt[i] = r_cnt[i];
    if (!r_primed) begin
      if (r_prime_cnt == PRIME_LAST) w_filt_nxt = w_sync;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (FILT_CYCLES == 0) begin
          w_filt_nxt[i] = w_sync[i];
        end else if (w_sync[i] == r_filt[i]) begin
          w_cnt_nxt[i] = 4'd0;
        end else if (r_cnt[i] == FILT_LAST) begin
          w_filt_nxt[i] = w_sync[i];
          w_cnt_nxt[i]  = 4'd0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_evt  = r_primed ? (w_filt_nxt ^ r_filt) : '0;
  assign w_rise = w_evt & w_filt_nxt;
  assign w_fall = w_evt & r_filt;
  assign w_set  = (w_rise & ioc_pos_conf) | (w_fall & ioc_neg_conf);

  assign w_wr_flg = wen && (address == ADDR_FLG);
  assign w_wr_msk = wen && (address == ADDR_MSK);
  assign w_clr    = int_ack  ? {WIDTH{1'b1}} :
                    w_wr_flg ? data_in[WIDTH-1:0] : '0;
  // A set event in the same cycle wins over any clear.
  assign w_flags_nxt = (r_flags & ~w_clr) | w_set;

  // Stage: flags, mask, priming and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt      <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= 4'd0;
      r_flags     <= '0;
      r_mask      <= '1;
      r_prime_cnt <= 3'd0;
      r_primed    <= 1'b0;
      r_port_out  <= 8'd0;
    end else begin
      r_filt  <= w_filt_nxt;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_flags <= w_flags_nxt;
      if (w_wr_msk) r_mask <= data_in[WIDTH-1:0];
      if (!r_primed) begin
        if (r_prime_cnt == PRIME_LAST) r_primed <= 1'b1;
        else                           r_prime_cnt <= r_prime_cnt + 3'd1;
      end
      // Reads see pre-edge state, so a read+clear returns the old flags.
      if (ren && address == ADDR)          r_port_out <= zext(r_filt);
      else if (ren && address == ADDR_FLG) r_port_out <= zext(r_flags);
      else if (ren && address == ADDR_MSK) r_port_out <= zext(r_mask);
      else                                 r_port_out <= 8'd0;
    end
  end

  assign port_out = r_port_out;
  assign int_out  = |(r_flags & r_mask);

endmodule

// File: tb/tb_inport_ioc_flt.sv
module tb_inport_ioc_flt;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: defaults (ADDR 03, WIDTH 8, SYNC 2, FILT 3)
  logic       rst0, ren0, wen0, ack0, int0;
  logic [7:0] addr0, din0, pin0, pos0, neg0, pout0;
  // DUT1: ADDR fe, WIDTH 4, SYNC 2, FILT 0
  logic       rst1, ren1, wen1, ack1, int1;
  logic [7:0] addr1, din1, pout1;
  logic [3:0] pin1, pos1, neg1;

  inport_ioc_flt #(.ADDR(8'h03), .WIDTH(8), .SYNC_STAGES(2), .FILT_CYCLES(3)) u0 (
    .clk(clk), .rst(rst0), .address(addr0), .ren(ren0), .wen(wen0), .data_in(din0),
    .port_in(pin0), .ioc_pos_conf(pos0), .ioc_neg_conf(neg0), .port_out(pout0),
    .int_out(int0), .int_ack(ack0));

  inport_ioc_flt #(.ADDR(8'hfe), .WIDTH(4), .SYNC_STAGES(2), .FILT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst1), .address(addr1), .ren(ren1), .wen(wen1), .data_in(din1),
    .port_in(pin1), .ioc_pos_conf(pos1), .ioc_neg_conf(neg1), .port_out(pout1),
    .int_out(int1), .int_ack(ack1));

  int total = 0;
  int bad   = 0;

  // Reference model configuration and state, one slot per DUT.
  int         cw [2] = '{8, 4};
  int         cs [2] = '{2, 2};
  int         cf [2] = '{3, 0};
  logic [7:0] ca [2] = '{8'h03, 8'hfe};

  int         mn [2];
  logic [7:0] mhist [2][16];
  logic [7:0] mfilt [2], mflags [2], mmask [2], mpout [2];
  logic       mprimed [2];
  int         mrun [2][8];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model of DUT d across one clock edge using the inputs
  // currently applied to that DUT.
  task automatic model_edge(input int d);
    logic       r, rn, wn, ak;
    logic [7:0] a, a1, a2, di, pi, po, ne, wm, sy, evt, rise, fall, clr, setv;
    wm = (cw[d] == 8) ? 8'hff : 8'((1 << cw[d]) - 1);
    if (d == 0) begin
      r = rst0; rn = ren0; wn = wen0; ak = ack0; a = addr0; di = din0;
      pi = pin0; po = pos0; ne = neg0;
    end else begin
      r = rst1; rn = ren1; wn = wen1; ak = ack1; a = addr1; di = din1;
      pi = {4'h0, pin1}; po = {4'h0, pos1}; ne = {4'h0, neg1};
    end
    if (r) begin
      mn[d] = 0; mfilt[d] = 8'h00; mflags[d] = 8'h00; mmask[d] = wm;
      mpout[d] = 8'h00; mprimed[d] = 1'b0;
      for (int b = 0; b < 8; b++) mrun[d][b] = 0;
      for (int k = 0; k < 16; k++) mhist[d][k] = 8'h00;
      return;
    end
    mn[d]++;
    // The synchronized value seen now is the input sampled cs edges ago.
    sy = (mn[d] - cs[d] >= 1) ? mhist[d][(mn[d] - cs[d]) % 16] : 8'h00;
    mhist[d][mn[d] % 16] = pi & wm;
    a1 = ca[d] + 8'd1;
    a2 = ca[d] + 8'd2;
    if (rn && a == ca[d])  mpout[d] = mfilt[d];
    else if (rn && a == a1) mpout[d] = mflags[d];
    else if (rn && a == a2) mpout[d] = mmask[d];
    else                    mpout[d] = 8'h00;
    evt = 8'h00;
    if (!mprimed[d]) begin
      if (mn[d] == cs[d] + 1) begin
        mfilt[d] = sy;
        mprimed[d] = 1'b1;
      end
    end else begin
      for (int b = 0; b < cw[d]; b++) begin
        if (sy[b] != mfilt[d][b]) begin
          mrun[d][b]++;
          if (mrun[d][b] >= cf[d]) begin
            evt[b] = 1'b1;
            mrun[d][b] = 0;
          end
        end else begin
          mrun[d][b] = 0;
        end
      end
    end
    rise = evt & sy;
    fall = evt & ~sy;
    setv = (rise & po) | (fall & ne);
    clr  = ak ? 8'hff : ((wn && a == a1) ? di : 8'h00);
    mflags[d] = ((mflags[d] & ~clr) | setv) & wm;
    if (wn && a == a2) mmask[d] = di & wm;
    mfilt[d] = (mfilt[d] ^ evt) & wm;
  endtask

  function automatic logic [7:0] exp_int(input int d);
    return {7'd0, |(mflags[d] & mmask[d])};
  endfunction

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    chk("pout0", pout0, mpout[0]);
    chk("int0", {7'd0, int0}, exp_int(0));
    chk("pout1", pout1, mpout[1]);
    chk("int1", {7'd0, int1}, exp_int(1));
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic rd0(input logic [7:0] a);
    addr0 = a; ren0 = 1'b1; tick(); ren0 = 1'b0;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [7:0] v);
    addr0 = a; din0 = v; wen0 = 1'b1; tick(); wen0 = 1'b0;
  endtask

  task automatic rd1(input logic [7:0] a);
    addr1 = a; ren1 = 1'b1; tick(); ren1 = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] v);
    addr1 = a; din1 = v; wen1 = 1'b1; tick(); wen1 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; ren0 = 1'b0; wen0 = 1'b0; ack0 = 1'b0;
    addr0 = 8'h00; din0 = 8'h00; pin0 = 8'h00; pos0 = 8'hff; neg0 = 8'hff;
    rst1 = 1'b1; ren1 = 1'b0; wen1 = 1'b0; ack1 = 1'b0;
    addr1 = 8'h00; din1 = 8'h00; pin1 = 4'h0; pos1 = 4'hf; neg1 = 4'hf;

    // Reset state
    tick();
    chk("rst_pout0", pout0, 8'h00);
    chk("rst_int0", {7'd0, int0}, 8'h00);
    rst0 = 1'b0; rst1 = 1'b0;
    wait_n(4);

    // Glitch rejection: two clocks high never reach the filtered value
    pin0 = 8'h01; wait_n(2);
    pin0 = 8'h00; wait_n(6);
    rd0(8'h03); chk("glitch_filt", pout0, 8'h00);
    rd0(8'h04); chk("glitch_flg", pout0, 8'h00);
    chk("glitch_int", {7'd0, int0}, 8'h00);
    pin0 = 8'h01; wait_n(3);
    pin0 = 8'h00; wait_n(6);
    rd0(8'h04); chk("hold3_flg", pout0, 8'h01);
    ack0 = 1'b1; tick(); ack0 = 1'b0;

    // Latency k+4 and basic reads
    pin0 = 8'haa; tick();
    wait_n(3); chk("lat_k3_int", {7'd0, int0}, 8'h00);
    tick();    chk("lat_k4_int", {7'd0, int0}, 8'h01);
    rd0(8'h03); chk("rd_filt", pout0, 8'haa);
    rd0(8'h04); chk("rd_flg", pout0, 8'haa);

    // W1C, mask, int_ack
    wr0(8'h04, 8'h0a);
    rd0(8'h04); chk("w1c_flg", pout0, 8'ha0);
    chk("w1c_int", {7'd0, int0}, 8'h01);
    wr0(8'h05, 8'h0f);
    chk("mask_int", {7'd0, int0}, 8'h00);
    rd0(8'h04); chk("mask_flg", pout0, 8'ha0);
    rd0(8'h05); chk("mask_rd", pout0, 8'h0f);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    rd0(8'h04); chk("ack_flg", pout0, 8'h00);
    wr0(8'h05, 8'hff);

    // Polarity selection
    pos0 = 8'h0f; neg0 = 8'hf0;
    pin0 = 8'h00; wait_n(8);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    pin0 = 8'hff; wait_n(8);
    rd0(8'h04); chk("pol_rise", pout0, 8'h0f);
    pin0 = 8'h00; wait_n(8);
    rd0(8'h04); chk("pol_fall", pout0, 8'hff);

    // Read and W1C together return the pre-clear flags
    addr0 = 8'h04; din0 = 8'hff; ren0 = 1'b1; wen0 = 1'b1; tick();
    ren0 = 1'b0; wen0 = 1'b0;
    chk("rw_pre", pout0, 8'hff);
    rd0(8'h04); chk("rw_post", pout0, 8'h00);
    pos0 = 8'hff; neg0 = 8'hff;

    // Set event colliding with int_ack
    pin0 = 8'h02; tick();
    wait_n(3);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    rd0(8'h04); chk("coll_flg", pout0, 8'h02);
    chk("coll_int", {7'd0, int0}, 8'h01);

    // Reset with inputs high: priming raises nothing
    pin0 = 8'hff; rst0 = 1'b1; tick(); rst0 = 1'b0;
    wait_n(5);
    rd0(8'h03); chk("prime_filt", pout0, 8'hff);
    rd0(8'h04); chk("prime_flg", pout0, 8'h00);
    chk("prime_int", {7'd0, int0}, 8'h00);

    // Narrow port, filter bypass, wrapped addresses
    pin1 = 4'h5; tick();
    tick(); chk("w4_k1_int", {7'd0, int1}, 8'h00);
    tick(); chk("w4_k2_int", {7'd0, int1}, 8'h01);
    rd1(8'hfe); chk("w4_filt", pout1, 8'h05);
    rd1(8'hff); chk("w4_flg", pout1, 8'h05);
    rd1(8'h00); chk("w4_mask", pout1, 8'h0f);
    wr1(8'h00, 8'hf3);
    rd1(8'h00); chk("w4_mask_wr", pout1, 8'h03);
    wr1(8'hff, 8'hff);
    rd1(8'hff); chk("w4_w1c", pout1, 8'h00);

    // Randomized traffic on both ports against the model
    for (int it = 0; it < 1500; it++) begin
      int sel;
      if ($urandom_range(0, 3) == 0) pin0 = pin0 ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pin1 = pin1 ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) pin0 = 8'($urandom);
      sel = $urandom_range(0, 3);
      addr0 = (sel == 3) ? 8'($urandom) : ca[0] + 8'(sel);
      sel = $urandom_range(0, 3);
      addr1 = (sel == 3) ? 8'($urandom) : ca[1] + 8'(sel);
      ren0 = 1'($urandom_range(0, 1)); ren1 = 1'($urandom_range(0, 1));
      wen0 = ($urandom_range(0, 3) == 0); wen1 = ($urandom_range(0, 3) == 0);
      din0 = 8'($urandom); din1 = 8'($urandom);
      ack0 = ($urandom_range(0, 15) == 0); ack1 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) begin
        pos0 = 8'($urandom); neg0 = 8'($urandom);
        pos1 = 4'($urandom); neg1 = 4'($urandom);
      end
      rst0 = ($urandom_range(0, 299) == 0);
      rst1 = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst0 = 1'b0; rst1 = 1'b0; ren0 = 1'b0; ren1 = 1'b0;
    wen0 = 1'b0; wen1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    wait_n(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inport_ioc_flt.md
Name: inport_ioc_flt

Overview:
- Parametrised successor to the PicoBlaze interrupt-on-change input port.
- Adds an input synchronizer, a per-bit glitch filter, per-bit sticky pending flags, a writable interrupt mask, and write-1-to-clear flag acknowledge.
- Sits on the 8-bit port bus alongside the other gio ports; all accesses use the bus address decode.
- port_out is zero whenever the port is not addressed, so it can be OR-combined with the other ports.

Parameters:
- ADDR, 8'h03: base address. ADDR = filtered input value (R), ADDR+1 = pending flags (R / W1C), ADDR+2 = interrupt mask (R/W).
- WIDTH, 8: number of input bits, range 1..8. Bus bits at WIDTH and above read 0; writes to those bits are ignored.
- SYNC_STAGES, 2: synchronizer flops, range 2..4.
- FILT_CYCLES, 3: consecutive clocks a new level must persist before it is accepted, range 0..15. A value of 0 bypasses the filter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- address  in  8  port address
- ren  in  1  read strobe
- wen  in  1  write strobe
- data_in  in  8  write data
- port_in  in  WIDTH  asynchronous external inputs
- ioc_pos_conf  in  WIDTH  per-bit rising-edge enable
- ioc_neg_conf  in  WIDTH  per-bit falling-edge enable
- port_out  out  8  registered read data
- int_out  out  1  interrupt request
- int_ack  in  1  clear all pending flags

Behaviour:
- Reset values: sync chain 0, filtered 0, filter counters 0, flags 0, mask all ones, port_out 0, int_out 0, primed 0.
- Priming after reset:
  - While primed=0, a counter runs for SYNC_STAGES clocks.
  - On the following edge: filtered <= sync output directly, no flags are set, primed <= 1.
  - Effect: a port that is already high at reset release raises no interrupt.
- Filter (per bit, primed=1, FILT_CYCLES>0), at each edge:
  - If sync == filtered: cnt <= 0.
  - Else if cnt == FILT_CYCLES-1: filtered <= sync, cnt <= 0, edge event generated.
  - Else: cnt <= cnt+1.
  - A pulse shorter than FILT_CYCLES clocks at the sync output never reaches filtered.
- Filter bypass (FILT_CYCLES=0): filtered <= sync every clock; an event is generated whenever they differ.
- Events:
  - Rising event (0->1) sets flag[i] if ioc_pos_conf[i].
  - Falling event (1->0) sets flag[i] if ioc_neg_conf[i].
- Latency: a port_in change sampled at edge k updates filtered and the flag at edge k+SYNC_STAGES+FILT_CYCLES-1 (FILT_CYCLES>0). int_out is high from that edge.
- int_out = |(flags & mask[WIDTH-1:0]). It is combinational from registers, with no extra delay.
- Flag clearing:
  - int_ack=1 clears all flags.
  - A write to ADDR+1 clears flags where data_in=1.
  - A set event in the same cycle wins over any clear for that bit.
- Mask: a write to ADDR+2 loads mask <= data_in[WIDTH-1:0]. Masked flags still latch and remain readable.
- Writes to ADDR, or to any unmatched address, have no effect.
- Reads:
  - If ren=1 and address is ADDR, ADDR+1 or ADDR+2: port_out <= zero-extended filtered / flags / mask on the next edge, 1-cycle latency.
  - Otherwise port_out <= 0.
  - A read does not clear flags.
- ren and wen asserted together at ADDR+1: the read returns the pre-clear flags; the clear takes effect on the same edge.
- Address wrap: ADDR+1 and ADDR+2 are computed modulo 256.
- Reset mid-operation: all state returns to reset values and priming restarts. Pending flags and filter counts are discarded.

Test Plan:
1. Defaults (WIDTH=8, conf 8'hff). Reset with port_in=8'h00, then port_in=8'haa at edge k -> flags=8'haa and int_out=1 at edge k+4. Read ADDR -> port_out=8'haa one clock after ren. Read ADDR+1 -> 8'haa.
2. Glitch rejection. port_in bit0 high for 2 clocks, then low -> filtered, flags and int_out unchanged. Hold bit0 high for 3 clocks -> flag[0]=1.
3. W1C and mask:
   - With flags=8'haa, write 8'h0a to ADDR+1 -> flags=8'ha0, int_out=1.
   - Write 8'h0f to ADDR+2 -> int_out=0, flags still read 8'ha0.
   - int_ack=1 -> flags=8'h00.
4. Polarity. ioc_pos_conf=8'h0f, ioc_neg_conf=8'hf0; port_in 8'h00->8'hff->8'h00 -> flags=8'h0f after the rise, 8'hff after the fall.
5. Collision and priming:
   - A rising event on bit1 in the same cycle as int_ack=1 -> flag[1]=1 afterwards.
   - Reset while port_in=8'hff -> after priming, filtered=8'hff, flags=8'h00, int_out=0.
6. Generic sweep. WIDTH=4, FILT_CYCLES=0, ADDR=8'hfe -> mask at address 8'h00. Read ADDR -> upper nibble 0. Latency is SYNC_STAGES edges.
